// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: result classes, opcode/funct constants, MD sequencer states.
// Also used by the result-class translator, so keep the encodings stable.
package pipe_pkg;

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC  = 2'b11
  } res_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // mult/multu/div/divu: the instructions that actually occupy the unit
  function automatic logic is_md_op(input logic [31:0] ins);
    return (ins[31:26] == OP_RTYPE) && (ins[5:2] == FN_MULT[5:2]);
  endfunction

  function automatic logic is_md_div(input logic [31:0] ins);
    return is_md_op(ins) && ins[1];
  endfunction

  // any of the 8 instructions that touch HI/LO
  function automatic logic is_md_any(input logic [31:0] ins);
    return (ins[31:26] == OP_RTYPE) &&
           ((ins[5:2] == FN_MULT[5:2]) || (ins[5:2] == FN_MFHI[5:2]));
  endfunction

endpackage

// File: rtl/md_seq.sv
// Multiply/divide occupancy sequencer: IDLE/BUSY state plus a down-counter of remaining cycles.
module md_seq
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_e,
  output logic        md_start,
  output logic        md_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 2);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 2);

  md_state_t  state_q;
  logic [3:0] cnt_q;

  // The start cycle itself counts as busy, so the counter covers only the remaining cycles.
  assign md_start = rst_n && (state_q == MD_IDLE) && is_md_op(instr_e);
  assign md_busy  = md_start || (state_q == MD_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md_start) begin
            state_q <= MD_BUSY;
            cnt_q   <= is_md_div(instr_e) ? DIV_LOAD : MULT_LOAD;
          end
        end
        MD_BUSY: begin
          if (cnt_q == 4'd0) state_q <= MD_IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, Tuse=0 branch/jump and MD-unit stalls, plus a stall counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_e,
  input  logic [1:0]  res_e,
  input  logic [1:0]  res_m,
  input  logic [4:0]  a3_e,
  input  logic [4:0]  a3_m,
  output logic        stall,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic [5:0]  op_d;
  logic [5:0]  fn_d;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic        use_rs;
  logic        use_rt;
  logic        tuse0;
  logic        match_e;
  logic        match_m;
  logic        stall_lu;
  logic        stall_br;
  logic        stall_md;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  assign op_d = instr_d[31:26];
  assign fn_d = instr_d[5:0];
  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];

  always_comb begin
    use_rs = 1'b1;
    use_rt = 1'b0;
    case (op_d)
      OP_RTYPE: begin
        case (fn_d)
          FN_JR, FN_MTHI, FN_MTLO: begin use_rs = 1'b1; use_rt = 1'b0; end
          FN_MFHI, FN_MFLO:        begin use_rs = 1'b0; use_rt = 1'b0; end
          default:                 begin use_rs = 1'b1; use_rt = 1'b1; end
        endcase
      end
      OP_BEQ, OP_BNE, OP_SW: begin use_rs = 1'b1; use_rt = 1'b1; end
      OP_J, OP_JAL, OP_LUI:  begin use_rs = 1'b0; use_rt = 1'b0; end
      default:               begin use_rs = 1'b1; use_rt = 1'b0; end
    endcase
  end

  // $0 is hard-wired, so a zero destination never produces a hazard.
  assign match_e = (a3_e != 5'd0) &&
                   ((use_rs && (rs_d == a3_e)) || (use_rt && (rt_d == a3_e)));
  assign match_m = (a3_m != 5'd0) &&
                   ((use_rs && (rs_d == a3_m)) || (use_rt && (rt_d == a3_m)));

  assign tuse0    = (op_d == OP_BEQ) || ((op_d == OP_RTYPE) && (fn_d == FN_JR));
  assign stall_lu = match_e && (res_e == RES_DM);
  assign stall_br = tuse0 &&
                    ((match_e && ((res_e == RES_ALU) || (res_e == RES_DM))) ||
                     (match_m && (res_m == RES_DM)));
  assign stall_md = is_md_any(instr_d) && md_busy;
  assign stall    = stall_lu || stall_br || stall_md;

  md_seq #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr_e  (instr_e),
    .md_start (md_start),
    .md_busy  (md_busy)
  );

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_hazard_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = NOP;
  logic [31:0] instr_e = NOP;
  logic [1:0]  res_e = 2'b00;
  logic [1:0]  res_m = 2'b00;
  logic [4:0]  a3_e = 5'd0;
  logic [4:0]  a3_m = 5'd0;
  logic        stall;
  logic        md_start;
  logic        md_busy;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr_d   (instr_d),
    .instr_e   (instr_e),
    .res_e     (res_e),
    .res_m     (res_m),
    .a3_e      (a3_e),
    .a3_m      (a3_m),
    .stall     (stall),
    .md_start  (md_start),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  // instruction encoders
  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] w;
    w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    return w;
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    return w;
  endfunction

  // reference model: which sources an instruction reads, {rs, rt}
  function automatic logic [1:0] m_uses(input logic [31:0] ins);
    int op;
    int fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    if (op == 0) begin
      if (fn == 8 || fn == 'h11 || fn == 'h13) return 2'b10;
      if (fn == 'h10 || fn == 'h12) return 2'b00;
      return 2'b11;
    end
    if (op == 4 || op == 5 || op == 'h2B) return 2'b11;
    if (op == 2 || op == 3 || op == 'h0F) return 2'b00;
    return 2'b10;
  endfunction

  function automatic bit m_md_unit(input logic [31:0] ins);
    int fn;
    fn = int'(ins[5:0]);
    return (ins[31:26] == 6'd0) && (fn >= 'h18) && (fn <= 'h1B);
  endfunction

  function automatic bit m_md_any(input logic [31:0] ins);
    int fn;
    fn = int'(ins[5:0]);
    return (ins[31:26] == 6'd0) && (((fn >= 'h18) && (fn <= 'h1B)) || ((fn >= 'h10) && (fn <= 'h13)));
  endfunction

  function automatic bit m_reads(input logic [31:0] ins, input logic [4:0] r);
    logic [1:0] u;
    u = m_uses(ins);
    if (r == 5'd0) return 1'b0;
    return (u[1] && ins[25:21] == r) || (u[0] && ins[20:16] == r);
  endfunction

  function automatic bit m_stall(input logic [31:0] d, input logic [1:0] re, input logic [4:0] ae,
                                 input logic [1:0] rm, input logic [4:0] am, input bit busy);
    bit he, hm, br;
    he = m_reads(d, ae);
    hm = m_reads(d, am);
    br = (d[31:26] == 6'd4) || (d[31:26] == 6'd0 && d[5:0] == 6'd8);
    if (he && re == 2'b10) return 1'b1;
    if (br && he && (re == 2'b01 || re == 2'b10)) return 1'b1;
    if (br && hm && rm == 2'b10) return 1'b1;
    if (m_md_any(d) && busy) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_idle();
    instr_d = NOP; instr_e = NOP;
    res_e = 2'b00; res_m = 2'b00; a3_e = 5'd0; a3_m = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (md_busy !== 1'b0 || md_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_md: busy=%b start=%b required 0/0", md_busy, md_start);
    end
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %h required 0", stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL post_reset: stall=%b busy=%b cnt=%h required 0/0/0", stall, md_busy, stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    drive_idle();
    instr_d = r_ins(8, 10, 9, 'h20); res_e = 2'b10; a3_e = 5'd8;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rs: stall=%b required 1", stall); end
    next_cycle();
    res_e = 2'b01;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_fwd_alu: stall=%b required 0", stall); end
    n_checks++;
    if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d required 1", stall_cnt); end
    res_e = 2'b10; a3_e = 5'd0; instr_d = r_ins(0, 10, 9, 'h20);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_zero: stall=%b required 0", stall); end
    a3_e = 5'd8; instr_d = r_ins(10, 8, 9, 'h20);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rt: stall=%b required 1", stall); end
    instr_d = i_ins('h23, 9, 8, 4);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_dest: stall=%b required 0", stall); end
    instr_d = i_ins('h2B, 9, 8, 4);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_sw_rt: stall=%b required 1", stall); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_branch();
    drive_idle();
    instr_d = i_ins(4, 3, 0, 16); res_m = 2'b10; a3_m = 5'd3;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL br_m_dm: stall=%b required 1", stall); end
    res_m = 2'b01;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL br_m_alu: stall=%b required 0", stall); end
    res_m = 2'b00; res_e = 2'b01; a3_e = 5'd3;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL br_e_alu: stall=%b required 1", stall); end
    res_e = 2'b11;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL br_e_pc: stall=%b required 0", stall); end
    instr_d = r_ins(3, 0, 0, 8); res_e = 2'b10;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL jr_e_dm: stall=%b required 1", stall); end
    res_e = 2'b00; res_m = 2'b11; a3_m = 5'd3;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL jr_m_pc: stall=%b required 0", stall); end
    instr_d = r_ins(3, 4, 5, 'h20); res_m = 2'b10;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL add_m_dm: stall=%b required 0", stall); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_md_timing();
    drive_idle();
    instr_d = r_ins(0, 0, 2, 'h12);
    for (int c = 0; c <= 5; c++) begin
      instr_e = (c == 0) ? r_ins(4, 5, 0, 'h18) : NOP;
      @(negedge clk);
      n_checks++;
      if (md_start !== (c == 0) || md_busy !== (c <= 4) || stall !== (c <= 4)) begin
        n_fail++;
        $display("FAIL md_timing c%0d: start=%b busy=%b stall=%b required %b/%b/%b",
                 c, md_start, md_busy, stall, c == 0, c <= 4, c <= 4);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    drive_idle();
    for (int c = 0; c <= 20; c++) exp_q.push_back({c == 0 || c == 10, c < 20, c <= 9});
    for (int c = 0; c <= 20; c++) begin
      instr_e = (c == 0) ? r_ins(6, 7, 0, 'h1A) : (c == 10) ? r_ins(6, 7, 0, 'h1B) : NOP;
      instr_d = (c <= 9) ? r_ins(6, 7, 0, 'h1B) : NOP;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({md_start, md_busy, stall} !== e) begin
        n_fail++;
        $display("FAIL b2b_div c%0d: start/busy/stall=%b required %b", c, {md_start, md_busy, stall}, e);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_div();
    drive_idle();
    instr_d = r_ins(0, 0, 2, 'h12);
    for (int c = 0; c <= 4; c++) begin
      instr_e = (c == 0) ? r_ins(6, 7, 0, 'h1A) : NOP;
      @(negedge clk);
      if (c < 4) next_cycle();
    end
    n_checks++;
    if (md_busy !== 1'b1 || stall_cnt === 32'd0) begin
      n_fail++; $display("FAIL rst_pre: busy=%b cnt=%h required busy=1 cnt>0", md_busy, stall_cnt);
    end
    instr_e = r_ins(6, 7, 0, 'h1A);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (md_busy !== 1'b0 || md_start !== 1'b0 || stall !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_div: busy=%b start=%b stall=%b cnt=%h required 0/0/0/0",
               md_busy, md_start, stall, stall_cnt);
    end
    next_cycle();
    instr_e = NOP;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (md_busy !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: busy=%b stall=%b required 0/0", md_busy, stall);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_saturation();
    drive_idle();
    @(negedge clk);
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    instr_d = r_ins(8, 10, 9, 'h20); res_e = 2'b10; a3_e = 5'd8;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall_cnt !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL sat_edge%0d: got %h required ffffffff", c, stall_cnt);
      end
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_random();
    int busy_left;
    logic [31:0] exp_cnt;
    bit e_start, e_busy, e_stall;
    logic [31:0] pool [17];
    drive_idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    next_cycle();
    busy_left = 0;
    exp_cnt = 32'd0;
    for (int c = 0; c < 400; c++) begin
      pool[0]  = NOP;
      pool[1]  = r_ins($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 'h20);
      pool[2]  = i_ins('h23, $urandom_range(0, 3), $urandom_range(0, 3), 8);
      pool[3]  = i_ins('h2B, $urandom_range(0, 3), $urandom_range(0, 3), 8);
      pool[4]  = i_ins('h0D, $urandom_range(0, 3), $urandom_range(0, 3), 1);
      pool[5]  = i_ins('h0F, $urandom_range(0, 3), $urandom_range(0, 3), 1);
      pool[6]  = i_ins(4, $urandom_range(0, 3), $urandom_range(0, 3), 2);
      pool[7]  = r_ins($urandom_range(0, 3), $urandom_range(0, 3), 0, 8);
      pool[8]  = i_ins(2, $urandom_range(0, 3), $urandom_range(0, 3), 3);
      for (int k = 0; k < 8; k++)
        pool[9 + k] = r_ins($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                            (k < 4) ? ('h18 + k) : ('h10 + k - 4));
      instr_d = pool[$urandom_range(0, 16)];
      instr_e = ($urandom_range(0, 5) == 0) ? pool[$urandom_range(9, 12)] : pool[$urandom_range(0, 8)];
      res_e = 2'($urandom_range(0, 3));
      res_m = 2'($urandom_range(0, 3));
      a3_e  = 5'($urandom_range(0, 3));
      a3_m  = 5'($urandom_range(0, 3));
      @(negedge clk);
      e_start = (busy_left == 0) && m_md_unit(instr_e);
      e_busy  = e_start || (busy_left > 0);
      e_stall = m_stall(instr_d, res_e, a3_e, res_m, a3_m, e_busy);
      n_checks++;
      if (stall !== e_stall) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %b required %b d=%h", c, stall, e_stall, instr_d);
      end
      n_checks++;
      if (md_start !== e_start) begin
        n_fail++; $display("FAIL rnd_start c%0d: got %b required %b", c, md_start, e_start);
      end
      n_checks++;
      if (md_busy !== e_busy) begin
        n_fail++; $display("FAIL rnd_busy c%0d: got %b required %b", c, md_busy, e_busy);
      end
      n_checks++;
      if (stall_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL rnd_cnt c%0d: got %0d required %0d", c, stall_cnt, exp_cnt);
      end
      if (e_stall) exp_cnt = exp_cnt + 32'd1;
      if (e_start) busy_left = m_md_unit(instr_e) && instr_e[1] ? DIV_CYC - 1 : MULT_CYC - 1;
      else if (busy_left > 0) busy_left = busy_left - 1;
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_md_timing();
    test_back_to_back();
    test_reset_mid_div();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
